// File: rtl/vfr_ctrl_pkg.sv
// Shared types and legality helper for the video frame-reader launch controller.
package vfr_ctrl_pkg;

   // Widest address the shadow config can hold; narrower AW is zero-extended.
   localparam int unsigned MaxAw = 64;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StWait  = 3'd1,
      StRun   = 3'd2,
      StDrain = 3'd3,
      StErr   = 3'd4
   } state_e;

   typedef struct packed {
      logic [1:0]       mode;
      logic [15:0]      width;
      logic [15:0]      height;
      logic [MaxAw-1:0] baseaddr;
   } cfg_t;

   // align_bytes must be a power of two (reader bus width in bytes).
   function automatic logic cfg_legal(input cfg_t        cfg,
                                      input int unsigned max_width,
                                      input int unsigned max_height,
                                      input int unsigned align_bytes);
      logic [MaxAw-1:0] align_mask;
      align_mask = MaxAw'(align_bytes) - MaxAw'(1);
      return (cfg.width != 16'd0) && (32'(cfg.width) <= max_width) &&
             (cfg.height != 16'd0) && (32'(cfg.height) <= max_height) &&
             ((cfg.baseaddr & align_mask) == '0);
   endfunction

endpackage

// File: rtl/vfr_cfg_check.sv
// Combinational legality check of a frame configuration.
module vfr_cfg_check
   import vfr_ctrl_pkg::*;
#(
   parameter int unsigned MAX_WIDTH  = 640,
   parameter int unsigned MAX_HEIGHT = 512,
   parameter int unsigned DW_MM      = 64
) (
   input  cfg_t cfg,
   output logic legal
);

   // Every mode encoding is accepted.
   logic unused_mode;
   assign unused_mode = ^cfg.mode;

   assign legal = cfg_legal(cfg, MAX_WIDTH, MAX_HEIGHT, DW_MM / 8);

endmodule

// File: rtl/vfr_launch_ctrl.sv
// Launch/sequencing controller for NUM_CH frame readers: delayed start, shadowed config
// committed at frame boundaries, graceful stop, frame watchdog and sticky status.
module vfr_launch_ctrl
   import vfr_ctrl_pkg::*;
#(
   parameter int unsigned NUM_CH      = 1,
   parameter int unsigned AW          = 32,
   parameter int unsigned DW_MM       = 64,
   parameter int unsigned MAX_WIDTH   = 640,
   parameter int unsigned MAX_HEIGHT  = 512,
   parameter int unsigned START_DELAY = 50,
   parameter logic [31:0] CH_STRIDE   = 32'h0010_0000,
   parameter int unsigned TIMEOUT_CYC = 2**24
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 go,
   input  logic                 cfg_update,
   input  logic [1:0]           mode,
   input  logic [15:0]          width,
   input  logic [15:0]          height,
   input  logic [AW-1:0]        baseaddr,
   input  logic [NUM_CH-1:0]    frame_done,
   output logic [NUM_CH-1:0]    rd_go,
   output logic [1:0]           rd_mode,
   output logic [15:0]          rd_width,
   output logic [15:0]          rd_height,
   output logic [NUM_CH*AW-1:0] rd_baseaddr,
   output logic                 busy,
   output logic                 cfg_err,
   output logic                 timeout,
   output logic [31:0]          frame_cnt
);

   localparam int unsigned    DlyW    = $clog2(START_DELAY + 1);
   localparam int unsigned    WdW     = $clog2(TIMEOUT_CYC);
   localparam logic [DlyW-1:0] DlyLast = DlyW'(START_DELAY - 1);
   localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT_CYC - 2);

   state_e              state;
   cfg_t                shadow;
   logic                pending;
   logic [NUM_CH-1:0]   done_mask;
   logic [DlyW-1:0]     dly_cnt;
   logic [WdW-1:0]      wdog;
   logic                shadow_legal;
   logic                running;
   logic                boundary;
   logic                dly_done;
   logic                commit;
   logic [AW-1:0]       ch_addr [NUM_CH];

   vfr_cfg_check #(
      .MAX_WIDTH  (MAX_WIDTH),
      .MAX_HEIGHT (MAX_HEIGHT),
      .DW_MM      (DW_MM)
   ) u_cfg_check (
      .cfg   (shadow),
      .legal (shadow_legal)
   );

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam logic [AW-1:0] Offset = AW'(64'(c) * 64'(CH_STRIDE));
      assign ch_addr[c] = shadow.baseaddr[AW-1:0] + Offset;
   end

   assign running  = (state == StRun) || (state == StDrain);
   // This cycle's pulses count towards completing the frame.
   assign boundary = running && (&(done_mask | frame_done));
   assign dly_done = (dly_cnt == DlyLast);
   assign commit   = ((state == StWait) && go && dly_done && shadow_legal) ||
                     (boundary && pending && shadow_legal);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= StIdle;
         shadow    <= '0;
         pending   <= 1'b0;
         done_mask <= '0;
         dly_cnt   <= '0;
         wdog      <= '0;
         frame_cnt <= '0;
         rd_go     <= '0;
         busy      <= 1'b0;
         cfg_err   <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (go) begin
                  state     <= StWait;
                  busy      <= 1'b1;
                  shadow    <= '{mode: mode, width: width, height: height,
                                 baseaddr: MaxAw'(baseaddr)};
                  pending   <= 1'b0;
                  dly_cnt   <= '0;
                  frame_cnt <= '0;
                  cfg_err   <= 1'b0;
                  timeout   <= 1'b0;
               end
            end
            StWait: begin
               if (!go) begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end else if (dly_done) begin
                  wdog      <= '0;
                  done_mask <= '0;
                  if (shadow_legal) begin
                     state <= StRun;
                     rd_go <= '1;
                  end else begin
                     state   <= StErr;
                     cfg_err <= 1'b1;
                  end
               end else begin
                  dly_cnt <= dly_cnt + 1'b1;
               end
            end
            StRun, StDrain: begin
               if (boundary) begin
                  done_mask <= '0;
                  frame_cnt <= frame_cnt + 32'd1;
                  wdog      <= '0;
                  pending   <= 1'b0;
                  if (pending && !shadow_legal) cfg_err <= 1'b1;
               end else begin
                  done_mask <= done_mask | frame_done;
                  wdog      <= wdog + 1'b1;
               end
               // Placed after the commit so a same-cycle update stays pending.
               if (cfg_update) begin
                  shadow  <= '{mode: mode, width: width, height: height,
                               baseaddr: MaxAw'(baseaddr)};
                  pending <= 1'b1;
               end
               if (!boundary && (wdog == WdLast)) begin
                  state     <= StErr;
                  timeout   <= 1'b1;
                  rd_go     <= '0;
                  done_mask <= '0;
               end else if (state == StRun) begin
                  if (!go) state <= StDrain;
               end else if (boundary) begin
                  state <= StIdle;
                  busy  <= 1'b0;
                  rd_go <= '0;
               end else if (go) begin
                  state <= StRun;
               end
            end
            StErr: begin
               if (!go) begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   // Active config seen by the readers; only changes on launch or boundary commit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_mode     <= '0;
         rd_width    <= '0;
         rd_height   <= '0;
         rd_baseaddr <= '0;
      end else if (commit) begin
         rd_mode   <= shadow.mode;
         rd_width  <= shadow.width;
         rd_height <= shadow.height;
         for (int c = 0; c < NUM_CH; c++) begin
            rd_baseaddr[c*AW +: AW] <= ch_addr[c];
         end
      end
   end

endmodule

// File: tb/tb_vfr_launch_ctrl.sv
// Directed self-checking bench for vfr_launch_ctrl (2 channels, short watchdog).
module tb_vfr_launch_ctrl;

   localparam int unsigned NUM_CH = 2;
   localparam int unsigned AW     = 32;

   logic                 clk;
   logic                 reset_n;
   logic                 go;
   logic                 cfg_update;
   logic [1:0]           mode;
   logic [15:0]          width;
   logic [15:0]          height;
   logic [AW-1:0]        baseaddr;
   logic [NUM_CH-1:0]    frame_done;
   logic [NUM_CH-1:0]    rd_go;
   logic [1:0]           rd_mode;
   logic [15:0]          rd_width;
   logic [15:0]          rd_height;
   logic [NUM_CH*AW-1:0] rd_baseaddr;
   logic                 busy;
   logic                 cfg_err;
   logic                 timeout;
   logic [31:0]          frame_cnt;

   int n_chk;
   int n_fail;

   vfr_launch_ctrl #(
      .NUM_CH      (NUM_CH),
      .AW          (AW),
      .DW_MM       (64),
      .MAX_WIDTH   (640),
      .MAX_HEIGHT  (512),
      .START_DELAY (50),
      .CH_STRIDE   (32'h0010_0000),
      .TIMEOUT_CYC (1000)
   ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .go          (go),
      .cfg_update  (cfg_update),
      .mode        (mode),
      .width       (width),
      .height      (height),
      .baseaddr    (baseaddr),
      .frame_done  (frame_done),
      .rd_go       (rd_go),
      .rd_mode     (rd_mode),
      .rd_width    (rd_width),
      .rd_height   (rd_height),
      .rd_baseaddr (rd_baseaddr),
      .busy        (busy),
      .cfg_err     (cfg_err),
      .timeout     (timeout),
      .frame_cnt   (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_chk      = 0;
      n_fail     = 0;
      reset_n    = 1'b0;
      go         = 1'b0;
      cfg_update = 1'b0;
      mode       = 2'd0;
      width      = 16'd0;
      height     = 16'd0;
      baseaddr   = '0;
      frame_done = '0;
      tick(2);
      chk("rst_rd_go", rd_go, 0);
      chk("rst_busy", busy, 0);
      chk("rst_width", rd_width, 0);
      chk("rst_base", rd_baseaddr, 0);
      chk("rst_fcnt", frame_cnt, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_timeout", timeout, 0);
      reset_n = 1'b1;
      tick(1);

      // Launch with a legal 640x512 config; rd_go rises START_DELAY edges after go.
      mode     = 2'd1;
      width    = 16'd640;
      height   = 16'd512;
      baseaddr = 32'h1000_0000;
      go       = 1'b1;
      tick(1);
      chk("wait_busy", busy, 1);
      chk("wait_rd_go", rd_go, 0);
      tick(49);
      chk("rd_go_early", rd_go, 0);
      tick(1);
      chk("rd_go_launch", rd_go, 2'b11);
      chk("launch_width", rd_width, 640);
      chk("launch_height", rd_height, 512);
      chk("launch_mode", rd_mode, 1);
      chk("launch_base", rd_baseaddr, {32'h1010_0000, 32'h1000_0000});

      // Mid-frame update commits only after both channels finish.
      width      = 16'd320;
      height     = 16'd256;
      cfg_update = 1'b1;
      tick(1);
      cfg_update = 1'b0;
      chk("upd_hold0", rd_width, 640);
      frame_done = 2'b01;
      tick(1);
      frame_done = 2'b00;
      chk("upd_hold1", rd_width, 640);
      chk("upd_fcnt0", frame_cnt, 0);
      tick(3);
      frame_done = 2'b10;
      tick(1);
      frame_done = 2'b00;
      chk("upd_width", rd_width, 320);
      chk("upd_height", rd_height, 256);
      chk("upd_fcnt1", frame_cnt, 1);

      // Same-cycle update and boundary: older shadow commits, newer waits.
      width      = 16'd160;
      height     = 16'd128;
      cfg_update = 1'b1;
      tick(1);
      width      = 16'd80;
      height     = 16'd64;
      frame_done = 2'b11;
      tick(1);
      cfg_update = 1'b0;
      frame_done = 2'b00;
      chk("same_width", rd_width, 160);
      chk("same_fcnt", frame_cnt, 2);
      tick(2);
      frame_done = 2'b11;
      tick(1);
      frame_done = 2'b00;
      chk("next_width", rd_width, 80);
      chk("next_height", rd_height, 64);
      chk("next_fcnt", frame_cnt, 3);

      // Repeated done on ch0 does not make a boundary on its own.
      frame_done = 2'b01;
      tick(1);
      frame_done = 2'b00;
      tick(1);
      frame_done = 2'b01;
      tick(1);
      frame_done = 2'b00;
      chk("rep_fcnt", frame_cnt, 3);
      frame_done = 2'b10;
      tick(1);
      frame_done = 2'b00;
      chk("rep_fcnt_bnd", frame_cnt, 4);

      // Graceful stop: rd_go held until the frame finishes.
      frame_done = 2'b01;
      tick(1);
      frame_done = 2'b00;
      go         = 1'b0;
      tick(1);
      chk("drain_rd_go", rd_go, 2'b11);
      chk("drain_busy", busy, 1);
      tick(5);
      chk("drain_hold", rd_go, 2'b11);
      frame_done = 2'b10;
      tick(1);
      frame_done = 2'b00;
      chk("stop_rd_go", rd_go, 0);
      chk("stop_busy", busy, 0);
      chk("stop_fcnt", frame_cnt, 5);

      // go dropped during the start delay: readers never start.
      go = 1'b1;
      tick(1);
      chk("relaunch_fcnt", frame_cnt, 0);
      tick(29);
      go = 1'b0;
      tick(1);
      chk("abort_busy", busy, 0);
      tick(30);
      chk("abort_rd_go", rd_go, 0);

      // Zero width is rejected at the end of the delay.
      width = 16'd0;
      go    = 1'b1;
      tick(50);
      chk("w0_pre_rd_go", rd_go, 0);
      chk("w0_pre_err", cfg_err, 0);
      tick(1);
      chk("w0_err", cfg_err, 1);
      chk("w0_rd_go", rd_go, 0);
      chk("w0_busy", busy, 1);
      chk("w0_active_held", rd_width, 80);
      go = 1'b0;
      tick(1);
      chk("w0_idle_busy", busy, 0);
      chk("w0_sticky", cfg_err, 1);

      // Misaligned base: relaunch clears the flag, then it is set again.
      width    = 16'd640;
      height   = 16'd512;
      baseaddr = 32'h1000_0004;
      go       = 1'b1;
      tick(1);
      chk("mis_clear", cfg_err, 0);
      tick(50);
      chk("mis_err", cfg_err, 1);
      chk("mis_rd_go", rd_go, 0);
      go = 1'b0;
      tick(1);

      // Watchdog: no frame_done for 999 cycles after entering RUN.
      baseaddr = 32'h2000_0000;
      go       = 1'b1;
      tick(51);
      chk("wd_rd_go", rd_go, 2'b11);
      chk("wd_base", rd_baseaddr, {32'h2010_0000, 32'h2000_0000});
      tick(998);
      chk("wd_pre_timeout", timeout, 0);
      chk("wd_pre_rd_go", rd_go, 2'b11);
      tick(1);
      chk("wd_timeout", timeout, 1);
      chk("wd_rd_go_off", rd_go, 0);
      chk("wd_busy", busy, 1);
      go = 1'b0;
      tick(1);
      chk("wd_idle", busy, 0);
      chk("wd_sticky", timeout, 1);

      // Illegal config at a boundary is refused; active config kept.
      go = 1'b1;
      tick(1);
      chk("wd_clear", timeout, 0);
      tick(50);
      chk("ill_rd_go", rd_go, 2'b11);
      height     = 16'd600;
      cfg_update = 1'b1;
      tick(1);
      cfg_update = 1'b0;
      frame_done = 2'b11;
      tick(1);
      frame_done = 2'b00;
      chk("ill_err", cfg_err, 1);
      chk("ill_height", rd_height, 512);
      chk("ill_fcnt", frame_cnt, 1);

      // Asynchronous reset while running.
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_rd_go", rd_go, 0);
      chk("arst_busy", busy, 0);
      chk("arst_width", rd_width, 0);
      chk("arst_base", rd_baseaddr, 0);
      chk("arst_err", cfg_err, 0);
      chk("arst_fcnt", frame_cnt, 0);
      go = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
